// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
// Command-to-APB requester. Accepts one read/write command at a time over a
// valid/ready port, runs a two-phase APB transfer (SETUP, ACCESS), waits on
// pready, and returns a one-cycle response pulse. A watchdog aborts an ACCESS
// phase that sees pready low for TIMEOUT cycles (TIMEOUT = 0 disables it).
//
// Ports
//   pclk, rst_n        clock, synchronous active-low reset
//   cmd_valid/ready    command handshake (cmd_ready is combinational: IDLE)
//   cmd_write/addr/wdata  command payload
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata          read data (0 for writes and aborts)
//   rsp_err            pslverr at completion, or 1 on watchdog abort
//   rsp_timeout        set with rsp_valid when the watchdog aborted
//   paddr/psel/penable/pwrite/pwdata   APB requester outputs (registered)
//   pready/prdata/pslverr              APB responder inputs
// ----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    // Watchdog width: ceil(log2(TIMEOUT+1)), at least one bit when disabled.
    localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    logic [WD_W-1:0] r_wdog;
    logic [WD_W-1:0] w_wdog_inc;
    logic            w_wdog_hit;

    // Saturating increment so the counter never wraps back below TIMEOUT.
    assign w_wdog_inc = (r_wdog == {WD_W{1'b1}}) ? r_wdog : r_wdog + WD_W'(1);
    assign w_wdog_hit = (TIMEOUT != 0) && (32'(w_wdog_inc) >= TIMEOUT);

    assign cmd_ready = (r_state == ST_IDLE);

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wdog      <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    r_wdog  <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Completion takes priority over a watchdog hit on the same edge.
                    if (pready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wdog <= w_wdog_inc;
                        if (w_wdog_hit) begin
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
